// File: rtl/fixed_multiplier_if.sv
// Start/done handshake and operand/result bus for the fixed-point shift-add multiplier.
interface fixed_multiplier_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic [WIDTH-1:0] in_A;
  logic [WIDTH-1:0] in_B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q_out;
  logic             ovf;

  modport master (
    output start, in_A, in_B,
    input  ready, busy, done, q_out, ovf
  );

  modport slave (
    input  start, in_A, in_B,
    output ready, busy, done, q_out, ovf
  );
endinterface

// File: rtl/fixed_multiplier.sv
// Sequential shift-add multiplier for unsigned Q(WIDTH-FRAC).FRAC operands:
// q_out = (in_A * in_B) >> FRAC, truncated, with overflow flag; one product bit per cycle.
module fixed_multiplier #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 4
) (
  input  logic                clk,
  input  logic                sclr,
  fixed_multiplier_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   m;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   q_out_r;
  logic               ovf_r;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;
  logic               zero_op;
  logic               last_iter;

  // Scales the full product down to the result format: {overflow, truncated result}.
  function automatic logic [WIDTH:0] trunc_ovf(input logic [2*WIDTH-1:FRAC] p);
    return {|p[2*WIDTH-1:FRAC+WIDTH], p[FRAC+WIDTH-1:FRAC]};
  endfunction

  assign sum       = acc + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
  assign shifted   = {sum, q} >> 1;
  assign zero_op   = (bus.in_A == '0) || (bus.in_B == '0);
  assign last_iter = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (sclr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_nxt = zero_op ? DONE : CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, one shift-add step per CALC cycle.
  always_ff @(posedge clk) begin
    if (sclr) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      cnt     <= '0;
      q_out_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m   <= bus.in_A;
            q   <= bus.in_B;
            acc <= '0;
            cnt <= '0;
            if (zero_op) begin
              q_out_r <= '0;
              ovf_r   <= 1'b0;
            end
          end
        end
        CALC: begin
          acc <= shifted[2*WIDTH:WIDTH];
          q   <= shifted[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (last_iter) {ovf_r, q_out_r} <= trunc_ovf(shifted[2*WIDTH-1:FRAC]);
        end
        default: ;
      endcase
    end
  end

  assign bus.q_out = q_out_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_fixed_multiplier.sv
// Directed-vector bench for fixed_multiplier (WIDTH=10, FRAC=4).
module tb_fixed_multiplier;

  logic clk = 1'b0;
  logic sclr;
  int   n_vec = 0;
  int   n_bad = 0;

  fixed_multiplier_if #(.WIDTH(10)) bus();

  fixed_multiplier #(.WIDTH(10), .FRAC(4)) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Launches one op from a negedge; optionally disturbs start/operands mid-CALC.
  task automatic run_op(input string tag, input logic [9:0] a, input logic [9:0] b,
                        input int exp_q, input int exp_ovf, input int exp_lat,
                        input bit disturb);
    int  n;
    int  nbusy;
    bit  seen;
    bus.in_A  = a;
    bus.in_B  = b;
    bus.start = 1'b1;
    n = 0; nbusy = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (disturb && n == 3) begin
        bus.start = 1'b1;
        bus.in_A  = 10'd1023;
        bus.in_B  = 10'd1023;
      end else if (disturb && n == 5) begin
        bus.in_A = 10'd5;
        bus.in_B = 10'd0;
      end
      if (bus.busy) nbusy++;
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    check_val({tag, " latency"}, n, exp_lat);
    check_val({tag, " q_out"}, int'(bus.q_out), exp_q);
    check_val({tag, " ovf"}, int'(bus.ovf), exp_ovf);
    check_val({tag, " busy_cycles"}, nbusy, exp_lat - 1);
    @(negedge clk);
    check_val({tag, " done_width"}, int'(bus.done), 0);
    check_val({tag, " ready_after"}, int'(bus.ready), 1);
    check_val({tag, " q_out_hold"}, int'(bus.q_out), exp_q);
  endtask

  initial begin
    int n;
    int first_done;
    int second_done;
    int spurious;

    sclr      = 1'b1;
    bus.start = 1'b0;
    bus.in_A  = '0;
    bus.in_B  = '0;
    repeat (3) @(negedge clk);
    check_val("rst ready", int'(bus.ready), 1);
    check_val("rst busy",  int'(bus.busy),  0);
    check_val("rst done",  int'(bus.done),  0);
    check_val("rst q_out", int'(bus.q_out), 0);
    check_val("rst ovf",   int'(bus.ovf),   0);
    sclr = 1'b0;
    @(negedge clk);

    run_op("nominal",   10'd48,   10'd40,  120, 0, 11, 0);
    run_op("overflow",  10'd1023, 10'd1023, 896, 1, 11, 0);
    run_op("zeroA",     10'd0,    10'd700,   0, 0,  1, 0);
    run_op("unit",      10'd16,   10'd700, 700, 0, 11, 0);
    run_op("zeroB",     10'd700,  10'd0,     0, 0,  1, 0);
    run_op("underflow", 10'd1,    10'd1,     0, 0, 11, 0);
    run_op("disturb",   10'd48,   10'd40,  120, 0, 11, 1);

    // start held high: second op starts the cycle after done
    bus.in_A  = 10'd16;
    bus.in_B  = 10'd700;
    bus.start = 1'b1;
    n = 0; first_done = 0; second_done = 0;
    while (second_done == 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        if (first_done == 0) begin
          first_done = n;
          bus.in_A = 10'd48;
          bus.in_B = 10'd40;
        end else begin
          second_done = n;
        end
      end
      if (first_done != 0 && n == first_done + 1)
        check_val("b2b gap_ready", int'(bus.ready), 1);
    end
    bus.start = 1'b0;
    check_val("b2b first_done",  first_done,  11);
    check_val("b2b second_done", second_done, 23);
    check_val("b2b q_out", int'(bus.q_out), 120);
    @(negedge clk);

    // sclr mid-CALC: abort, no done pulse
    bus.in_A  = 10'd1023;
    bus.in_B  = 10'd1023;
    bus.start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    check_val("abort ready", int'(bus.ready), 1);
    check_val("abort busy",  int'(bus.busy),  0);
    check_val("abort q_out", int'(bus.q_out), 0);
    check_val("abort ovf",   int'(bus.ovf),   0);
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done || bus.busy) spurious++;
      @(negedge clk);
    end
    check_val("abort no_done", spurious, 0);
    run_op("post_abort", 10'd48, 10'd40, 120, 0, 11, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
